serial_tx: RTL and testbench

//  - Serial transmitter: loads a parallel byte and shifts it out as an asynchronous frame.
//  - Frame order: start bit (0), DATA_BITS data bits LSB first, optional parity bit, stop bit (1).
//  - Transmit-side partner of the serial receiver datapath.
//  - Uses the same ClearCounter/IncCounter bit-count control style as the BitCounter block.

---
 rtl/serial_tx_pkg.sv | 40 ++++
 rtl/serial_tx_bit_counter.sv | 22 ++
 rtl/serial_tx.sv | 136 +++++++++++++
 tb/tb_serial_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding,
// parity mode codes and the parity helper used when a byte is loaded.
package serial_tx_pkg;

  // Transmit FSM states, one per field of the serial frame
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity mode codes matching the PARITY parameter of serial_tx
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit for the low nbits of data: plain XOR gives even parity,
  // the inverted XOR gives odd parity. Returns 0 when parity is disabled.
  function automatic logic frame_parity(input logic [7:0] data,
                                        input int unsigned nbits,
                                        input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) begin
        p = p ^ data[i];
      end
    end
    if (mode == PAR_ODD) begin
      frame_parity = ~p;
    end else if (mode == PAR_EVEN) begin
      frame_parity = p;
    end else begin
      frame_parity = 1'b0;
    end
  endfunction

endpackage

// File: rtl/serial_tx_bit_counter.sv
// Data-bit counter for the serial transmitter. The owning FSM clears it
// when a frame enters its data field and increments it at every bit boundary.
module BitCounter (
  input  logic       clk,
  input  logic       reset,
  input  logic       ClearCounter,
  input  logic       IncCounter,
  output logic [7:0] Count
);

  // Clear has priority over increment so a new frame always starts at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      Count <= 8'd0;
    end else if (ClearCounter) begin
      Count <= 8'd0;
    end else if (IncCounter) begin
      Count <= Count + 8'd1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: accepts a parallel byte with a
// ready/start handshake and sends start bit, LSB-first data bits,
// optional parity bit and stop bit, each CLKS_PER_BIT clocks long.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  output logic       TxReady,
  output logic       TxDone,
  output logic       SerialOut
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] DONE_AT   = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [7:0] LAST_BIT  = 8'(DATA_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_count;
  logic [7:0]        shreg;
  logic              parity_bit;
  logic [7:0]        bit_count;
  logic              baud_wrap;
  logic              clear_counter;
  logic              inc_counter;

  assign baud_wrap     = (baud_count == BAUD_LAST);
  assign clear_counter = (state == ST_START) && baud_wrap;
  assign inc_counter   = (state == ST_DATA) && baud_wrap;

  BitCounter u_bit_counter (
    .clk          (clk),
    .reset        (reset),
    .ClearCounter (clear_counter),
    .IncCounter   (inc_counter),
    .Count        (bit_count)
  );

  // Frame sequencer: owns the baud counter, shift register and all
  // registered outputs so the line only changes on bit boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      baud_count <= '0;
      shreg      <= 8'd0;
      parity_bit <= 1'b0;
      SerialOut  <= 1'b1;
      TxReady    <= 1'b1;
      TxDone     <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          baud_count <= '0;
          if (TxStart && TxReady) begin
            shreg      <= TxData & DATA_MASK;
            parity_bit <= frame_parity(TxData, DATA_BITS, PARITY);
            SerialOut  <= 1'b0;
            TxReady    <= 1'b0;
            state      <= ST_START;
          end
        end

        ST_START: begin
          if (baud_wrap) begin
            baud_count <= '0;
            SerialOut  <= shreg[0];
            state      <= ST_DATA;
          end else begin
            baud_count <= baud_count + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_wrap) begin
            baud_count <= '0;
            shreg      <= {1'b0, shreg[7:1]};
            if (bit_count == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                SerialOut <= parity_bit;
                state     <= ST_PARITY;
              end else begin
                SerialOut <= 1'b1;
                state     <= ST_STOP;
              end
            end else begin
              SerialOut <= shreg[1];
            end
          end else begin
            baud_count <= baud_count + 1'b1;
          end
        end

        ST_PARITY: begin
          if (baud_wrap) begin
            baud_count <= '0;
            SerialOut  <= 1'b1;
            state      <= ST_STOP;
          end else begin
            baud_count <= baud_count + 1'b1;
          end
        end

        ST_STOP: begin
          SerialOut <= 1'b1;
          if (baud_wrap) begin
            baud_count <= '0;
            TxReady    <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            baud_count <= baud_count + 1'b1;
            if (baud_count == DONE_AT) begin
              TxDone <= 1'b1;
            end
          end
        end

        default: begin
          baud_count <= '0;
          SerialOut  <= 1'b1;
          TxReady    <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: four instances cover no parity, even
// parity, odd parity and a 5-bit data width. Expected line bits are
// queued when a frame is requested and popped while the line is watched.
module tb_serial_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start [4];
  logic       ser_out  [4];
  logic       tx_ready [4];
  logic       tx_done  [4];

  int checks   = 0;
  int failures = 0;

  logic exp_bits [$];
  int   exp_len  [$];

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) dut_none (
    .clk(clk), .reset(reset), .TxData(tx_data), .TxStart(tx_start[0]),
    .TxReady(tx_ready[0]), .TxDone(tx_done[0]), .SerialOut(ser_out[0]));

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1)) dut_even (
    .clk(clk), .reset(reset), .TxData(tx_data), .TxStart(tx_start[1]),
    .TxReady(tx_ready[1]), .TxDone(tx_done[1]), .SerialOut(ser_out[1]));

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2)) dut_odd (
    .clk(clk), .reset(reset), .TxData(tx_data), .TxStart(tx_start[2]),
    .TxReady(tx_ready[2]), .TxDone(tx_done[2]), .SerialOut(ser_out[2]));

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0)) dut_five (
    .clk(clk), .reset(reset), .TxData(tx_data), .TxStart(tx_start[3]),
    .TxReady(tx_ready[3]), .TxDone(tx_done[3]), .SerialOut(ser_out[3]));

  function automatic int cfg_bits(input int idx);
    return (idx == 3) ? 5 : 8;
  endfunction

  function automatic int cfg_par(input int idx);
    return (idx == 1) ? 1 : ((idx == 2) ? 2 : 0);
  endfunction

  task automatic check(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  // Build the expected line bit sequence for one frame on instance idx
  task automatic push_frame(input int idx, input logic [7:0] data);
    int ones;
    int n;
    ones = 0;
    n = 0;
    exp_bits.push_back(1'b0);
    n++;
    for (int i = 0; i < cfg_bits(idx); i++) begin
      exp_bits.push_back(data[i]);
      if (data[i]) ones++;
      n++;
    end
    if (cfg_par(idx) == 1) begin
      exp_bits.push_back((ones % 2) == 1);
      n++;
    end else if (cfg_par(idx) == 2) begin
      exp_bits.push_back((ones % 2) == 0);
      n++;
    end
    exp_bits.push_back(1'b1);
    n++;
    exp_len.push_back(n);
  endtask

  // Called at a falling edge; the frame is accepted on the next rising edge
  task automatic apply_stimulus(input int idx, input logic [7:0] data, input bit hold);
    tx_data = data;
    tx_start[idx] = 1'b1;
    push_frame(idx, data);
    @(posedge clk);
    #1;
    if (!hold) tx_start[idx] = 1'b0;
  endtask

  // Watch every cycle of the next queued frame, then the idle cycle after it
  task automatic check_output(input int idx, input string tag);
    int   n;
    logic e;
    if (exp_len.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1'b1, 1'b0);
      return;
    end
    n = exp_len.pop_front();
    for (int b = 0; b < n; b++) begin
      e = exp_bits.pop_front();
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        check({tag, "_line"}, ser_out[idx], e);
        check({tag, "_done"}, tx_done[idx], (b == n - 1) && (c == CPB - 1));
        check({tag, "_ready_busy"}, tx_ready[idx], 1'b0);
      end
    end
    @(negedge clk);
    check({tag, "_idle_line"}, ser_out[idx], 1'b1);
    check({tag, "_idle_ready"}, tx_ready[idx], 1'b1);
    check({tag, "_idle_done"}, tx_done[idx], 1'b0);
  endtask

  task automatic idle_cycles(input int idx, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_line"}, ser_out[idx], 1'b1);
      check({tag, "_ready"}, tx_ready[idx], 1'b1);
    end
  endtask

  // Directed sequence of frames, busy-time requests and resets
  initial begin
    reset = 1'b1;
    tx_data = 8'h00;
    for (int i = 0; i < 4; i++) tx_start[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_line", ser_out[i], 1'b1);
      check("reset_ready", tx_ready[i], 1'b1);
      check("reset_done", tx_done[i], 1'b0);
    end

    apply_stimulus(0, 8'hA5, 1'b0);
    check_output(0, "none_a5");

    apply_stimulus(1, 8'h07, 1'b0);
    check_output(1, "even_07");
    apply_stimulus(2, 8'h07, 1'b0);
    check_output(2, "odd_07");
    apply_stimulus(1, 8'h96, 1'b0);
    check_output(1, "even_96");
    apply_stimulus(2, 8'hC1, 1'b0);
    check_output(2, "odd_c1");

    apply_stimulus(0, 8'h5A, 1'b0);
    fork
      check_output(0, "busy_5a");
      begin
        repeat (10) @(negedge clk);
        tx_data = 8'hFF;
        tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
        repeat (12) @(negedge clk);
        tx_data = 8'h00;
        tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
      end
    join
    idle_cycles(0, 4, "after_busy");

    apply_stimulus(0, 8'h00, 1'b1);
    push_frame(0, 8'hFF);
    fork
      check_output(0, "b2b_00");
      begin
        repeat (8) @(negedge clk);
        tx_data = 8'hFF;
      end
    join
    fork
      check_output(0, "b2b_ff");
      begin
        repeat (5) @(negedge clk);
        tx_start[0] = 1'b0;
      end
    join
    idle_cycles(0, 3, "after_b2b");

    apply_stimulus(0, 8'h96, 1'b0);
    repeat (18) @(negedge clk);
    check("midrst_pre_line", ser_out[0], 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_bits.delete();
    exp_len.delete();
    check("midrst_line", ser_out[0], 1'b1);
    check("midrst_ready", tx_ready[0], 1'b1);
    check("midrst_done", tx_done[0], 1'b0);
    idle_cycles(0, 8, "midrst_idle");
    apply_stimulus(0, 8'h3C, 1'b0);
    check_output(0, "post_rst_3c");

    reset = 1'b1;
    tx_data = 8'hAA;
    tx_start[0] = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tx_start[0] = 1'b0;
    check("rst_start_line", ser_out[0], 1'b1);
    check("rst_start_ready", tx_ready[0], 1'b1);
    idle_cycles(0, 6, "rst_start_idle");

    apply_stimulus(3, 8'hFF, 1'b0);
    check_output(3, "five_ff");
    apply_stimulus(3, 8'hE2, 1'b0);
    check_output(3, "five_e2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
